r_type_encoder: RTL and testbench
=================================

Name: r_type_encoder

Overview:
- Inverse of the R-type decode stage: turns a one-hot ALU-operation vector plus register indices into a 32-bit RV32I R-type instruction word (OP opcode 0110011).
- Sits in the test/stimulus infrastructure and instruction-generation path, feeding the fetch/decode side.
- Input side is a valid/ready handshake. Output side is a parameterised FIFO with its own valid/ready handshake.
- Illegal operation vectors are detected, dropped and counted.

Parameters:
- DEPTH, 2: output FIFO entries; legal range 1..16.
- CNT_W, 16: width of the emitted and illegal counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- in_valid  input  1  request carries a valid operation.
- in_ready  output  1  encoder can accept a request this cycle.
- is_add, is_sub, is_sll, is_slt, is_sltu, is_xor, is_srl, is_sra, is_or, is_and  input  1 each  one-hot operation select.
- rd  input  5  destination register index.
- rs1  input  5  source register 1 index.
- rs2  input  5  source register 2 index.
- out_valid  output  1  instr holds a valid encoded word.
- out_ready  input  1  consumer accepts instr this cycle.
- instr  output  32  encoded instruction (FIFO head).
- err_illegal  output  1  one-cycle pulse when an illegal request is dropped.
- emitted_count  output  CNT_W  legal words pushed into the FIFO, saturating.
- illegal_count  output  CNT_W  illegal requests dropped, saturating.

Behaviour:
- Reset (rst=0, async assert, sync deassert at next clk edge):
  - FIFO empty, read/write pointers = 0.
  - out_valid=0, instr=0, err_illegal=0, both counters=0.
  - in_ready=0 while rst=0.
  - Reset mid-operation discards all FIFO contents and clears the counters.
- Accept: a request is accepted on a rising edge when in_valid && in_ready.
- in_ready = (occupancy < DEPTH). There is no same-cycle pass-through when the FIFO is full, even if out_ready=1.
- Legality: the request is legal iff exactly one of the ten is_* inputs is 1.
- Encoding of a legal request: instr = {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
  - funct3: add/sub=000, sll=001, slt=010, sltu=011, xor=100, srl/sra=101, or=110, and=111.
  - funct7: 0100000 for sub and sra, 0000000 for all others.
- Legal accept:
  - Encoded word written at the write pointer.
  - emitted_count +1, saturating at all-ones.
- Illegal accept (zero-hot or multi-hot):
  - Handshake still completes; nothing is written to the FIFO.
  - err_illegal=1 for exactly the following cycle.
  - illegal_count +1, saturating at all-ones.
- Latency: a word accepted at edge N has out_valid=1 and appears on instr after edge N (registered, 1 cycle) if the FIFO was empty.
- Output side:
  - out_valid = (occupancy != 0).
  - instr = head entry; instr = 0 when the FIFO is empty.
  - Pop on a rising edge when out_valid && out_ready.
  - instr holds stable while out_valid && !out_ready.
- Simultaneous push and pop (non-full, non-empty FIFO): occupancy unchanged, both pointers advance.
- Simultaneous illegal accept and pop: pop proceeds and occupancy decrements.
- Pointers wrap modulo DEPTH. Occupancy is tracked in a separate counter of width clog2(DEPTH+1).
- Ordering: strict FIFO, no reordering or coalescing.
- Inputs are sampled only at an accepting edge and are don't-care otherwise.

Test Plan:
- ADD: reset, then accept is_add, rd=3, rs1=1, rs2=2, out_ready=1 -> next cycle out_valid=1, instr=0x002081B3; emitted_count=1.
- SUB/SRA back-to-back: accept SUB x5,x6,x7 then SRA x1,x2,x3 with out_ready=0 -> after the second accept in_ready=0 (DEPTH=2). Then raise out_ready -> instr=0x407302B3, then 0x403150B3, then out_valid=0.
- AND on maximum fields: accept is_and with rd=rs1=rs2=31 -> instr=0x01FFFFB3.
- Illegal vectors: accept with all is_* = 0, then with is_add=is_or=1 -> err_illegal pulses once per request; FIFO stays empty; illegal_count=2; emitted_count unchanged.
- Full with simultaneous push/pop: FIFO full, out_ready=1, in_valid=1 -> no accept that cycle; next cycle accept and pop together, occupancy stays 1. Run all ten ops in sequence and check each funct3/funct7 field.
- Mid-operation reset: FIFO holds 2 words, assert rst=0 asynchronously between edges -> out_valid, instr and the counters go to 0 immediately; after release, first output is the first new request.

Source files
------------

// File: rtl/r_type_encoder.sv
// RV32I R-type encoder: one-hot ALU op + register indices -> OP word, pushed into a DEPTH-entry FIFO (1-cycle latency when empty).
// Backpressure: in_ready drops while the FIFO is full; illegal (not exactly one-hot) requests are accepted, dropped and counted.
module r_type_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_add,
  input  logic             is_sub,
  input  logic             is_sll,
  input  logic             is_slt,
  input  logic             is_sltu,
  input  logic             is_xor,
  input  logic             is_srl,
  input  logic             is_sra,
  input  logic             is_or,
  input  logic             is_and,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             err_illegal,
  output logic [CNT_W-1:0] emitted_count,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [OCC_W-1:0] r_count;
  logic             r_err;
  logic [CNT_W-1:0] r_emitted;
  logic [CNT_W-1:0] r_illegal;

  logic [9:0]  w_ops;
  logic        w_legal;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_word;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  assign w_ops   = {is_and, is_or, is_sra, is_srl, is_xor, is_sltu, is_slt, is_sll, is_sub, is_add};
  assign w_legal = $onehot(w_ops);

  // funct3 bits are the OR of the ops whose code has that bit set; only sub/sra carry funct7[5].
  assign w_funct3[0] = is_sll | is_sltu | is_srl | is_sra | is_and;
  assign w_funct3[1] = is_slt | is_sltu | is_or  | is_and;
  assign w_funct3[2] = is_xor | is_srl  | is_sra | is_or  | is_and;
  assign w_funct7    = {1'b0, is_sub | is_sra, 5'b0};
  assign w_word      = {w_funct7, rs2, rs1, w_funct3, rd, 7'b0110011};

  assign in_ready  = rst && (r_count < OCC_FULL);
  assign out_valid = (r_count != '0);
  assign instr     = out_valid ? r_mem[r_rptr] : 32'h0;

  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = out_valid && out_ready;

  assign err_illegal   = r_err;
  assign emitted_count = r_emitted;
  assign illegal_count = r_illegal;

  // Storage needs no reset: entries are only visible through a non-zero occupancy.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_emitted <= '0;
      r_illegal <= '0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_push) begin
        r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + PTR_ONE;
        if (r_emitted != CNT_MAX) r_emitted <= r_emitted + CNT_ONE;
      end
      if (w_accept && !w_legal && (r_illegal != CNT_MAX)) r_illegal <= r_illegal + CNT_ONE;
      if (w_pop) r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + OCC_ONE;
      else if (w_pop && !w_push) r_count <= r_count - OCC_ONE;
    end
  end

endmodule

// File: tb/tb_r_type_encoder.sv
// Randomized + directed bench for r_type_encoder against a queue-based reference model.
module tb_r_type_encoder;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [9:0] ops = '0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] instr;
  logic err_illegal;
  logic [CNT_W-1:0] emitted_count, illegal_count;

  r_type_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .is_add(ops[0]), .is_sub(ops[1]), .is_sll(ops[2]), .is_slt(ops[3]), .is_sltu(ops[4]),
    .is_xor(ops[5]), .is_srl(ops[6]), .is_sra(ops[7]), .is_or(ops[8]), .is_and(ops[9]),
    .rd(rd), .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .err_illegal(err_illegal), .emitted_count(emitted_count), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: op index order add,sub,sll,slt,sltu,xor,srl,sra,or,and.
  int unsigned f3_tab [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  int unsigned f7_tab [10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
  logic [31:0] q_m [$];
  int unsigned emit_m = 0, ill_m = 0;
  logic err_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_encode(input logic [9:0] v, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    int idx = 0;
    for (int i = 0; i < 10; i++) if (v[i]) idx = i;
    return f7_tab[idx] * 32'h0200_0000 + s2 * 32'h0010_0000 + s1 * 32'h0000_8000
         + f3_tab[idx] * 32'h0000_1000 + d * 32'h0000_0080 + 32'h33;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, q_m.size() != 0});
    check({tag, ".instr"}, instr, (q_m.size() != 0) ? q_m[0] : 32'h0);
    check({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, rst && (q_m.size() < DEPTH)});
    check({tag, ".err"}, {31'b0, err_illegal}, {31'b0, err_m});
    check({tag, ".emitted"}, {16'b0, emitted_count}, emit_m);
    check({tag, ".illegal"}, {16'b0, illegal_count}, ill_m);
  endtask

  // Inputs are driven at the falling edge; model advances on the rising edge; DUT checked at the next falling edge.
  task automatic step(input string tag);
    int ones;
    bit acc, pop;
    @(posedge clk);
    ones = 0;
    for (int i = 0; i < 10; i++) ones += ops[i];
    acc = in_valid && rst && (q_m.size() < DEPTH);
    pop = (q_m.size() != 0) && out_ready && rst;
    err_m = acc && (ones != 1);
    if (pop) void'(q_m.pop_front());
    if (acc && ones == 1) begin
      q_m.push_back(model_encode(ops, rd, rs1, rs2));
      if (emit_m != 32'hFFFF) emit_m++;
    end
    if (acc && ones != 1 && ill_m != 32'hFFFF) ill_m++;
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic [9:0] o, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic ordy);
    in_valid = v; ops = o; rd = d; rs1 = s1; rs2 = s2; out_ready = ordy;
  endtask

  initial begin
    #1;
    check("reset.out_valid", {31'b0, out_valid}, 32'h0);
    check("reset.instr", instr, 32'h0);
    check("reset.in_ready", {31'b0, in_ready}, 32'h0);
    check("reset.err", {31'b0, err_illegal}, 32'h0);
    check("reset.counts", {emitted_count, illegal_count}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs("post_reset");

    // ADD x3,x1,x2
    drive(1, 10'b1, 3, 1, 2, 1); step("add");
    check("add.word", instr, 32'h002081B3);
    drive(0, 10'b0, 0, 0, 0, 1); step("add_drain");

    // SUB then SRA with consumer stalled, then drain
    drive(1, 10'b10, 5, 6, 7, 0); step("sub");
    drive(1, 10'b1000_0000, 1, 2, 3, 0); step("sra");
    check("full.in_ready", {31'b0, in_ready}, 32'h0);
    drive(0, 10'b0, 0, 0, 0, 0); step("hold");
    check("hold.word", instr, 32'h407302B3);
    out_ready = 1'b1;
    check("sub.word", instr, 32'h407302B3);
    step("pop_sub");
    check("sra.word", instr, 32'h403150B3);
    step("pop_sra");
    check("drained", {31'b0, out_valid}, 32'h0);

    // AND on maximum register fields
    drive(1, 10'b10_0000_0000, 31, 31, 31, 0); step("and");
    check("and.word", instr, 32'h01FFFFB3);
    drive(0, 10'b0, 0, 0, 0, 1); step("and_drain");

    // Illegal: zero-hot then add|or
    drive(1, 10'b0, 1, 1, 1, 1); step("ill0");
    drive(1, 10'b1_0000_0001, 1, 1, 1, 1); step("ill2");
    check("ill.count", {16'b0, illegal_count}, 32'd2);
    drive(0, 10'b0, 0, 0, 0, 1); step("ill_done");

    // Full FIFO with simultaneous push/pop
    drive(1, 10'b100, 4, 5, 6, 0); step("fill0");
    drive(1, 10'b1000, 7, 8, 9, 0); step("fill1");
    drive(1, 10'b10000, 10, 11, 12, 1); step("full_no_accept");
    step("push_pop");
    check("push_pop.occ1", {31'b0, in_ready}, 32'h1);
    drive(0, 10'b0, 0, 0, 0, 1); step("pp_drain0"); step("pp_drain1");

    // All ten ops, field check against the literal funct tables
    for (int i = 0; i < 10; i++) begin
      logic [9:0] oh;
      oh = 10'b1 << i;
      drive(1, oh, 5'(i), 5'(i + 1), 5'(i + 2), 1); step("op_seq");
      check("op_seq.f3", {29'b0, instr[14:12]}, f3_tab[i]);
      check("op_seq.f7", {25'b0, instr[31:25]}, f7_tab[i]);
    end
    drive(0, 10'b0, 0, 0, 0, 1); step("op_seq_drain");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [9:0] o;
      if ($urandom_range(0, 7) == 0) o = 10'($urandom);
      else o = 10'b1 << $urandom_range(0, 9);
      drive(1'($urandom_range(0, 3) != 0), o, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom_range(0, 2) != 0));
      step("rand");
    end

    // Mid-operation asynchronous reset with two words held
    drive(1, 10'b1, 1, 2, 3, 0); step("pre_rst0");
    drive(1, 10'b100000, 4, 5, 6, 0); step("pre_rst1");
    drive(0, 10'b0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    check("arst.out_valid", {31'b0, out_valid}, 32'h0);
    check("arst.instr", instr, 32'h0);
    check("arst.in_ready", {31'b0, in_ready}, 32'h0);
    check("arst.counts", {emitted_count, illegal_count}, 32'h0);
    q_m.delete(); emit_m = 0; ill_m = 0; err_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(1, 10'b10_0000_0000, 9, 8, 7, 0); step("post_arst");
    check("post_arst.word", instr, model_encode(10'b10_0000_0000, 9, 8, 7));
    drive(0, 10'b0, 0, 0, 0, 1); step("post_arst_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end
endmodule
